// File: rtl/sdram_cpu_bridge.sv
// Byte-wide CPU bus to 16-bit toggle-handshake SDRAM port bridge with a
// single-word read buffer (write-through on tag match).
module sdram_cpu_bridge #(
  parameter int DATA_DELAY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  output logic        bus_busy,
  input  logic        inval,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  output logic        mem_we,
  input  logic [15:0] mem_dout,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DWAIT = 2'd2;

  localparam int CW = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_DELAY - 1);

  // Handshake: mem_req toggles once per request; the request is complete
  // when mem_ack has toggled to match it (mem_req == mem_ack means idle).

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          buf_valid;
  logic [22:0]   buf_tag;
  logic [15:0]   buf_data;
  logic          rd_lsb;
  logic          fill_blocked;

  logic          strobe;
  logic          tag_hit;
  logic          ack_seen;
  logic [7:0]    hit_byte;
  logic [7:0]    fill_byte;

  assign state_dbg = state;
  assign strobe    = (bus_rd | bus_wr) & ~bus_busy & (state == ST_IDLE);
  assign tag_hit   = buf_valid & (buf_tag == bus_addr[23:1]);
  assign ack_seen  = (mem_ack == mem_req);
  assign hit_byte  = bus_addr[0] ? buf_data[15:8] : buf_data[7:0];
  assign fill_byte = rd_lsb ? mem_dout[15:8] : mem_dout[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bus_busy     <= 1'b0;
      bus_dout     <= 8'h00;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_data     <= '0;
      rd_lsb       <= 1'b0;
      fill_blocked <= 1'b0;
      mem_req      <= mem_ack;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_ds       <= 2'b00;
      mem_we       <= 1'b0;
    end else begin
      if (inval) buf_valid <= 1'b0;
      // An invalidate seen mid-fill must keep that fill from re-validating.
      if (inval && state != ST_IDLE) fill_blocked <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (strobe) begin
            if (bus_wr) begin
              mem_we       <= 1'b1;
              mem_addr     <= bus_addr[23:1];
              mem_din      <= {bus_din, bus_din};
              mem_ds       <= {bus_addr[0], ~bus_addr[0]};
              mem_req      <= ~mem_req;
              bus_busy     <= 1'b1;
              fill_blocked <= 1'b0;
              state        <= ST_REQ;
              if (tag_hit) begin
                if (bus_addr[0]) buf_data[15:8] <= bus_din;
                else             buf_data[7:0]  <= bus_din;
              end
            end else if (tag_hit && !inval) begin
              bus_dout <= hit_byte;
            end else begin
              mem_we       <= 1'b0;
              mem_addr     <= bus_addr[23:1];
              mem_ds       <= 2'b11;
              mem_req      <= ~mem_req;
              rd_lsb       <= bus_addr[0];
              bus_busy     <= 1'b1;
              fill_blocked <= 1'b0;
              state        <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (ack_seen) begin
            if (mem_we) begin
              bus_busy <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= ST_DWAIT;
            end
          end
        end
        ST_DWAIT: begin
          if (cnt == '0) begin
            buf_data  <= mem_dout;
            buf_tag   <= mem_addr;
            buf_valid <= ~(fill_blocked | inval);
            bus_dout  <= fill_byte;
            bus_busy  <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Directed bench for sdram_cpu_bridge: an SDRAM-side responder that drives
// mem_dout only on the exact sample cycle, plus scenario tasks.
module tb_sdram_cpu_bridge;

  localparam int DD = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic        bus_busy;
  logic        inval;
  logic        mem_req;
  logic        mem_ack;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_we;
  logic [15:0] mem_dout;
  logic [1:0]  state_dbg;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic exp_req;
  logic [7:0] exp_dout;

  sdram_cpu_bridge #(.DATA_DELAY(DD)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_rd(bus_rd),
    .bus_wr(bus_wr), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_busy(bus_busy), .inval(inval), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ds(mem_ds), .mem_we(mem_we), .mem_dout(mem_dout),
    .state_dbg(state_dbg)
  );

  // Clock and time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  // Read miss: ack arrives ack_dly cycles after the toggle; mem_dout is
  // correct only on the single cycle the bridge must sample it.
  task automatic do_read_miss(input logic [23:0] addr, input int ack_dly,
                              input logic [15:0] data, input int inval_at,
                              input int poke_at, input logic [23:0] poke_addr,
                              input logic inval_strobe, input string name);
    logic [7:0] exp_byte;
    exp_byte = addr[0] ? data[15:8] : data[7:0];
    mem_dout = ~data;
    bus_addr = addr;
    bus_rd   = 1'b1;
    inval    = inval_strobe;
    exp_req  = ~exp_req;
    @(negedge clk);
    bus_rd   = 1'b0;
    inval    = 1'b0;
    bus_addr = 24'h0;
    n_checks++;
    if (mem_req !== exp_req || mem_we !== 1'b0 || mem_ds !== 2'b11 ||
        mem_addr !== addr[23:1] || bus_busy !== 1'b1 || bus_dout !== exp_dout ||
        state_dbg !== 2'd1)
      begin
      n_fails++;
      $display("FAIL %s issue: req=%b we=%b ds=%b addr=%h busy=%b dout=%h st=%0d, want req=%b we=0 ds=11 addr=%h busy=1 dout=%h st=1",
               name, mem_req, mem_we, mem_ds, mem_addr, bus_busy, bus_dout, state_dbg,
               exp_req, addr[23:1], exp_dout);
    end
    repeat (ack_dly - 1) @(negedge clk);
    mem_ack = exp_req;
    for (int i = 0; i < DD; i++) begin
      @(negedge clk);
      inval  = (i == inval_at);
      bus_rd = (i == poke_at);
      if (i == poke_at) bus_addr = poke_addr;
      n_checks++;
      if (bus_busy !== 1'b1 || mem_req !== exp_req || bus_dout !== exp_dout ||
          mem_addr !== addr[23:1]) begin
        n_fails++;
        $display("FAIL %s wait%0d: busy=%b req=%b dout=%h addr=%h, want busy=1 req=%b dout=%h addr=%h",
                 name, i, bus_busy, mem_req, bus_dout, mem_addr, exp_req, exp_dout, addr[23:1]);
      end
      if (i == DD - 1) mem_dout = data;
    end
    @(negedge clk);
    inval    = 1'b0;
    bus_rd   = 1'b0;
    mem_dout = ~data;
    exp_dout = exp_byte;
    n_checks++;
    if (bus_busy !== 1'b0 || bus_dout !== exp_dout || mem_req !== exp_req ||
        state_dbg !== 2'd0) begin
      n_fails++;
      $display("FAIL %s fill: busy=%b dout=%h req=%b st=%0d, want busy=0 dout=%h req=%b st=0",
               name, bus_busy, bus_dout, mem_req, state_dbg, exp_dout, exp_req);
    end
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [7:0] data,
                          input int ack_dly, input logic rd_too, input string name);
    bus_addr = addr;
    bus_din  = data;
    bus_wr   = 1'b1;
    bus_rd   = rd_too;
    exp_req  = ~exp_req;
    @(negedge clk);
    bus_wr   = 1'b0;
    bus_rd   = 1'b0;
    bus_din  = 8'h00;
    bus_addr = 24'h0;
    n_checks++;
    if (mem_req !== exp_req || mem_we !== 1'b1 || mem_ds !== {addr[0], ~addr[0]} ||
        mem_din !== {data, data} || mem_addr !== addr[23:1] || bus_busy !== 1'b1 ||
        bus_dout !== exp_dout) begin
      n_fails++;
      $display("FAIL %s issue: req=%b we=%b ds=%b din=%h addr=%h busy=%b dout=%h, want req=%b we=1 ds=%b din=%h addr=%h busy=1 dout=%h",
               name, mem_req, mem_we, mem_ds, mem_din, mem_addr, bus_busy, bus_dout,
               exp_req, {addr[0], ~addr[0]}, {data, data}, addr[23:1], exp_dout);
    end
    repeat (ack_dly - 1) @(negedge clk);
    n_checks++;
    if (bus_busy !== 1'b1) begin
      n_fails++;
      $display("FAIL %s pre_ack: busy=%b, want 1", name, bus_busy);
    end
    mem_ack = exp_req;
    @(negedge clk);
    n_checks++;
    if (bus_busy !== 1'b0 || state_dbg !== 2'd0 || mem_we !== 1'b1 ||
        mem_din !== {data, data} || mem_addr !== addr[23:1]) begin
      n_fails++;
      $display("FAIL %s done: busy=%b st=%0d we=%b din=%h addr=%h, want busy=0 st=0 we=1 din=%h addr=%h",
               name, bus_busy, state_dbg, mem_we, mem_din, mem_addr, {data, data}, addr[23:1]);
    end
  endtask

  task automatic do_read_hit(input logic [23:0] addr, input logic [7:0] exp_byte,
                             input string name);
    bus_addr = addr;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd   = 1'b0;
    exp_dout = exp_byte;
    n_checks++;
    if (bus_dout !== exp_dout || bus_busy !== 1'b0 || mem_req !== exp_req) begin
      n_fails++;
      $display("FAIL %s hit: dout=%h busy=%b req=%b, want dout=%h busy=0 req=%b",
               name, bus_dout, bus_busy, mem_req, exp_dout, exp_req);
    end
    @(negedge clk);
    n_checks++;
    if (bus_busy !== 1'b0 || mem_req !== exp_req || state_dbg !== 2'd0) begin
      n_fails++;
      $display("FAIL %s hit_after: busy=%b req=%b st=%0d, want busy=0 req=%b st=0",
               name, bus_busy, mem_req, state_dbg, exp_req);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus_addr = 24'h0;
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    bus_din  = 8'h00;
    inval    = 1'b0;
    mem_ack  = 1'b1;
    mem_dout = 16'h0;
    exp_req  = 1'b1;
    exp_dout = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || bus_busy !== 1'b0 || bus_dout !== 8'h00 || mem_we !== 1'b0 ||
        mem_ds !== 2'b00 || mem_addr !== 23'h0 || mem_din !== 16'h0 || state_dbg !== 2'd0) begin
      n_fails++;
      $display("FAIL reset: req=%b busy=%b dout=%h we=%b ds=%b addr=%h din=%h st=%0d, want req=1 busy=0 dout=00 we=0 ds=00 addr=0 din=0 st=0",
               mem_req, bus_busy, bus_dout, mem_we, mem_ds, mem_addr, mem_din, state_dbg);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || bus_busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_fails++;
      $display("FAIL reset_idle: req=%b busy=%b st=%0d, want req=1 busy=0 st=0",
               mem_req, bus_busy, state_dbg);
    end
  endtask

  task automatic test_cold_read_miss();
    do_read_miss(24'h000101, 3, 16'hBEEF, -1, -1, 24'h0, 1'b0, "cold_miss");
  endtask

  task automatic test_read_hit();
    do_read_hit(24'h000100, 8'hEF, "hit_lo");
    do_read_hit(24'h000101, 8'hBE, "hit_hi");
  endtask

  task automatic test_write_through();
    do_write(24'h000100, 8'h5A, 2, 1'b0, "wr_hit");
    do_read_hit(24'h000100, 8'h5A, "wt_lo");
    do_read_hit(24'h000101, 8'hBE, "wt_hi");
    do_write(24'h000301, 8'h77, 1, 1'b0, "wr_miss");
    do_read_hit(24'h000100, 8'h5A, "wt_kept");
  endtask

  task automatic test_inval_during_fill();
    do_read_miss(24'h000200, 2, 16'h1234, 2, -1, 24'h0, 1'b0, "inval_fill");
    do_read_miss(24'h000200, 1, 16'h5678, -1, -1, 24'h0, 1'b0, "refetch");
    do_read_hit(24'h000201, 8'h56, "refetch_hit");
  endtask

  task automatic test_busy_ignore();
    do_read_miss(24'h000401, 2, 16'hA1B2, -1, 1, 24'h000200, 1'b0, "busy_poke");
    do_read_hit(24'h000400, 8'hB2, "busy_after");
  endtask

  task automatic test_rd_wr_together();
    do_write(24'h000400, 8'hC3, 3, 1'b1, "rd_wr");
    do_read_hit(24'h000400, 8'hC3, "rd_wr_lo");
    do_read_hit(24'h000401, 8'hA1, "rd_wr_hi");
  endtask

  task automatic test_inval_with_read();
    do_read_miss(24'h000401, 1, 16'hD4E5, -1, -1, 24'h0, 1'b1, "inval_strobe");
  endtask

  task automatic test_reset_in_dwait();
    do_write(24'h000601, 8'h11, 2, 1'b0, "pre_reset_wr");
    bus_addr = 24'h000700;
    bus_rd   = 1'b1;
    exp_req  = ~exp_req;
    @(negedge clk);
    bus_rd   = 1'b0;
    mem_ack  = exp_req;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'd2 || bus_busy !== 1'b1 || mem_req !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_dwait_pre: st=%0d busy=%b req=%b, want st=2 busy=1 req=1",
               state_dbg, bus_busy, mem_req);
    end
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_dout = 8'h00;
    mem_dout = 16'hFFFF;
    n_checks++;
    if (mem_req !== 1'b1 || bus_busy !== 1'b0 || state_dbg !== 2'd0 || bus_dout !== 8'h00 ||
        mem_we !== 1'b0 || mem_ds !== 2'b00 || mem_addr !== 23'h0 || mem_din !== 16'h0) begin
      n_fails++;
      $display("FAIL rst_dwait: req=%b busy=%b st=%0d dout=%h we=%b ds=%b addr=%h din=%h, want req=1 busy=0 st=0 dout=00 we=0 ds=00 addr=0 din=0",
               mem_req, bus_busy, state_dbg, bus_dout, mem_we, mem_ds, mem_addr, mem_din);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || bus_busy !== 1'b0 || bus_dout !== 8'h00) begin
      n_fails++;
      $display("FAIL rst_quiet: req=%b busy=%b dout=%h, want req=1 busy=0 dout=00",
               mem_req, bus_busy, bus_dout);
    end
    do_read_miss(24'h000401, 2, 16'h0F1E, -1, -1, 24'h0, 1'b0, "post_reset_miss");
    do_read_hit(24'h000400, 8'h1E, "post_reset_hit");
  endtask

  initial begin
    test_reset();
    test_cold_read_miss();
    test_read_hit();
    test_write_through();
    test_inval_during_fill();
    test_busy_ignore();
    test_rd_wr_together();
    test_inval_with_read();
    test_reset_in_dwait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sdram_cpu_bridge.md
SDRAM_CPU_BRIDGE -- requirements
Module: sdram_cpu_bridge

Interface
REQ-001 Parameter DATA_DELAY, default 5: clk cycles from observed mem_ack toggle to valid mem_dout.
REQ-002 clk  in  1  sole clock; every flop is rising-edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 bus_addr  in  24  CPU byte address; sampled on a strobe cycle.
REQ-005 bus_rd  in  1  one-cycle read strobe.
REQ-006 bus_wr  in  1  one-cycle write strobe.
REQ-007 bus_din  in  8  write byte; sampled with bus_wr.
REQ-008 bus_dout  out  8  read byte; registered.
REQ-009 bus_busy  out  1  high while an accepted access is outstanding.
REQ-010 inval  in  1  one-cycle pulse that invalidates the read buffer.
REQ-011 mem_req  out  1  toggle request to the SDRAM cpu port.
REQ-012 mem_ack  in  1  toggle acknowledge; mem_req == mem_ack means idle.
REQ-013 mem_addr  out  23  word address (bus_addr[23:1]).
REQ-014 mem_din  out  16  write data: {bus_din, bus_din}.
REQ-015 mem_ds  out  2  byte enables: {bus_addr[0], ~bus_addr[0]}; 2'b11 on reads.
REQ-016 mem_we  out  1  1 = write, 0 = read.
REQ-017 mem_dout  in  16  SDRAM read word.

Function
REQ-018 States: IDLE, REQ, DWAIT. Reset state is IDLE.
REQ-019 Read buffer fields:
- buf_valid, 1 bit.
- buf_tag, 23 bits.
- buf_data, 16 bits.
REQ-020 IDLE accepts a strobe only while bus_busy=0. A strobe while bus_busy=1 is ignored; no state, buffer or output changes.
REQ-021 bus_rd and bus_wr together: treat as a write; ignore the read.
REQ-022 Read hit (buf_valid and buf_tag==bus_addr[23:1]):
- bus_dout next cycle = buf_data[15:8] if bus_addr[0]=1, else buf_data[7:0].
- bus_busy stays 0; no mem_req toggle.
REQ-023 Read miss:
- Next cycle: mem_we=0, mem_ds=2'b11, mem_addr loaded, mem_req toggled, bus_busy=1, state REQ.
REQ-024 Write (hit or miss):
- Next cycle: mem_we=1, mem_addr/mem_din/mem_ds loaded, mem_req toggled, bus_busy=1, state REQ.
- On tag match, the addressed buf_data byte updates the same cycle (write-through).
REQ-025 REQ, read, when mem_ack==mem_req:
- Load counter with DATA_DELAY-1; go to DWAIT.
REQ-026 REQ, write, when mem_ack==mem_req:
- Go to IDLE; bus_busy=0 next cycle.
REQ-027 DWAIT: decrement counter each cycle. When the counter is 0, sample mem_dout the same cycle and set:
- buf_data=mem_dout, buf_tag=mem_addr, buf_valid=1 (unless blocked by REQ-029).
- bus_dout = addressed byte of mem_dout.
- bus_busy=0; state IDLE.
REQ-028 Timing: first mem_dout sample falls exactly DATA_DELAY cycles after the cycle mem_ack became equal to mem_req. Read-miss minimum latency, strobe to bus_busy low, = 2 + ack delay + DATA_DELAY cycles.
REQ-029 inval:
- Clears buf_valid next cycle.
- If inval arrives while in REQ/DWAIT for a read, that fill completes and drives bus_dout but leaves buf_valid=0.
REQ-030 inval on the same cycle as a read strobe: the read is treated as a miss.
REQ-031 mem_addr, mem_din, mem_ds and mem_we hold stable from the toggle until the next accepted access.
REQ-032 At most one request outstanding; mem_req toggles only from IDLE.

Reset
REQ-033 Reset values:
- State IDLE, bus_busy=0, bus_dout=8'h00, buf_valid=0.
- mem_we=0, mem_ds=2'b00, mem_addr=0, mem_din=0, counter=0.
REQ-034 On reset, mem_req loads the current mem_ack, so no spurious request is issued.
REQ-035 Reset mid-operation abandons the access. The late mem_ack/mem_dout of that access is ignored. The SDRAM side still completes its own transaction.

Verification
REQ-036 Cold read miss, bus_addr=24'h000101, ack 3 cycles after toggle, mem_dout=16'hBEEF -> mem_req toggles once, mem_ds=2'b11; bus_dout=8'hBE; bus_busy low DATA_DELAY cycles after ack.
REQ-037 Follow-up read at 24'h000100 -> bus_dout=8'hEF next cycle, bus_busy stays 0, no toggle.
REQ-038 Write 8'h5A at 24'h000100 with the buffer holding 16'hBEEF -> mem_din=16'h5A5A, mem_ds=2'b01, mem_we=1; buf_data=16'hBE5A; a later read of 24'h000100 returns 8'h5A without a toggle.
REQ-039 Read miss with inval pulsed during DWAIT -> bus_dout updated, buf_valid=0; re-read of the same address issues a new toggle.
REQ-040 bus_rd asserted while bus_busy=1 -> ignored: no extra toggle, bus_dout unchanged.
REQ-041 Reset asserted in DWAIT with mem_ack=1 -> mem_req=1, bus_busy=0, buf_valid=0; no toggle until the next strobe.
